// File: rtl/mem_ctrl.sv
// Byte-wide arbiter between MEM (always wins) and instruction fetch over a
// single-port synchronous RAM; IF words are assembled little-endian from four byte reads.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_r_w,
  input  logic [31:0]       mem_addr,
  input  logic [7:0]        mem_wdata,
  output logic [7:0]        mem_rdata,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_inst,
  output logic              if_done,
  output logic              if_busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] base_r;
  logic [2:0]        issued_r;
  logic              tag0_v_r, tag1_v_r;
  logic [1:0]        tag0_idx_r, tag1_idx_r;
  logic [23:0]       buf_r;
  logic [ADDR_W-1:0] ram_a_r;
  logic              ram_wr_r;
  logic [7:0]        ram_dout_r;
  logic [31:0]       if_inst_r;
  logic              if_done_r;
  logic              if_busy_r;

  logic              start_s, kill_s, issue_s, capture_s, done_s, busy_s;
  logic [1:0]        idx_s;
  logic [ADDR_W-1:0] base_s, fetch_a_s;
  logic              unused_s;

  // Per-edge arbitration: fetch start, abort, byte issue and byte capture
  always_comb begin
    start_s   = (state_r != FETCH) && if_req && !mem_req && !if_flush;
    kill_s    = if_flush || ((state_r == FETCH) && mem_req);
    issue_s   = start_s ||
                ((state_r == FETCH) && !mem_req && !if_flush && (issued_r < 3'd4));
    capture_s = (state_r == FETCH) && tag1_v_r && !kill_s;
    done_s    = capture_s && (tag1_idx_r == 2'd3);
    if (start_s) begin
      idx_s = 2'd0;
    end else begin
      idx_s = issued_r[1:0];
    end
    // A restart from HOLD reuses the base latched when the fetch first began
    if (state_r == IDLE) begin
      base_s = if_addr[ADDR_W-1:0];
    end else begin
      base_s = base_r;
    end
    fetch_a_s = base_s + ADDR_W'(idx_s);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush outranks both preemption and completion
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = FETCH;
        else         state_s = IDLE;
      end
      FETCH: begin
        if (if_flush)     state_s = IDLE;
        else if (mem_req) state_s = HOLD;
        else if (done_s)  state_s = IDLE;
        else              state_s = FETCH;
      end
      HOLD: begin
        if (if_flush)     state_s = IDLE;
        else if (start_s) state_s = FETCH;
        else              state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode for the registered busy flag
  always_comb begin
    busy_s = (state_s != IDLE);
  end

  // RAM port, owner tags, assembly buffer and fetch result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_a_r    <= '0;
      ram_wr_r   <= 1'b0;
      ram_dout_r <= 8'd0;
      base_r     <= '0;
      issued_r   <= 3'd0;
      tag0_v_r   <= 1'b0;
      tag0_idx_r <= 2'd0;
      tag1_v_r   <= 1'b0;
      tag1_idx_r <= 2'd0;
      buf_r      <= 24'd0;
      if_inst_r  <= 32'd0;
      if_done_r  <= 1'b0;
      if_busy_r  <= 1'b0;
    end else begin
      if (mem_req) begin
        ram_a_r    <= mem_addr[ADDR_W-1:0];
        ram_wr_r   <= mem_r_w;
        ram_dout_r <= mem_wdata;
      end else if (issue_s) begin
        ram_a_r  <= fetch_a_s;
        ram_wr_r <= 1'b0;
      end else begin
        ram_wr_r <= 1'b0;
      end
      if (start_s) begin
        base_r <= base_s;
      end
      if (issue_s) begin
        issued_r <= {1'b0, idx_s} + 3'd1;
      end
      // Stage 0 tags what was issued this edge; stage 1 lines up with ram_din
      tag0_v_r   <= issue_s;
      tag0_idx_r <= idx_s;
      tag1_v_r   <= tag0_v_r && !kill_s;
      tag1_idx_r <= tag0_idx_r;
      if (capture_s) begin
        case (tag1_idx_r)
          2'd0:    buf_r[7:0]   <= ram_din;
          2'd1:    buf_r[15:8]  <= ram_din;
          2'd2:    buf_r[23:16] <= ram_din;
          default: buf_r        <= buf_r;
        endcase
      end
      if (done_s) begin
        if_inst_r <= {ram_din, buf_r};
      end
      if_done_r <= done_s;
      if_busy_r <= busy_s;
    end
  end

  assign unused_s  = ^{mem_addr[31:ADDR_W], if_addr[31:ADDR_W]};
  assign mem_rdata = ram_din;
  assign ram_a     = ram_a_r;
  assign ram_wr    = ram_wr_r;
  assign ram_dout  = ram_dout_r;
  assign if_inst   = if_inst_r;
  assign if_done   = if_done_r;
  assign if_busy   = if_busy_r;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-wide memory arbiter between the instruction-fetch stage, the MEM stage and a single-port synchronous RAM. MEM issues one byte access per cycle and always wins arbitration; IF requests a full 32-bit instruction, which the controller assembles little-endian from four sequential byte reads. The controller sits directly downstream of MEM, consuming its `mem_req` byte requests and returning the byte MEM samples as its read data.

## Interface
- `ADDR_W`, 17, RAM address width; byte addresses are truncated to `[ADDR_W-1:0]`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst`=0 resets).
- `mem_req`  in  1  MEM byte access request, sampled every edge.
- `mem_r_w`  in  1  0 = read, 1 = write.
- `mem_addr`  in  32  MEM byte address.
- `mem_wdata`  in  8  MEM write byte.
- `mem_rdata`  out  8  read byte for MEM; combinational copy of `ram_din`.
- `if_req`  in  1  IF fetch request; held high until `if_done`.
- `if_addr`  in  32  instruction address; latched at fetch start.
- `if_flush`  in  1  abort the current fetch (branch redirect).
- `if_inst`  out  32  assembled instruction.
- `if_done`  out  1  one-cycle pulse; `if_inst` is valid in the same cycle.
- `if_busy`  out  1  fetch in progress, including a fetch paused by MEM.
- `ram_a`  out  ADDR_W  RAM address, registered.
- `ram_wr`  out  1  RAM write enable, registered.
- `ram_dout`  out  8  RAM write data, registered.
- `ram_din`  in  8  RAM read data, valid in the cycle after the RAM samples `ram_a`.

## Operation
- States: IDLE, FETCH, HOLD.
  - FETCH: issuing or collecting IF bytes.
  - HOLD: fetch preempted by MEM, waiting to restart.
- MEM path, in any state: when `mem_req`=1 at edge t, the controller registers `ram_a`=`mem_addr[ADDR_W-1:0]`, `ram_wr`=`mem_r_w`, `ram_dout`=`mem_wdata` at t.
  - For a read, the byte appears on `mem_rdata` during the cycle after t+1, so MEM samples it at edge t+2.
- Edges with no issuer register `ram_wr`=0. `ram_a` and `ram_dout` hold their previous values.
- IDLE → FETCH: at an edge with `if_req`=1, `mem_req`=0 and `if_flush`=0.
  - Latch `if_addr` as the base and issue byte 0 at that same edge.
- FETCH issue: issue bytes i=0..3 at consecutive edges, each with `ram_a`=(base+i)[ADDR_W-1:0].
  - The address wraps inside ADDR_W.
- Owner tracking: a 2-stage owner/valid shift register tags every issued read (IF byte index or MEM).
  - Only IF-tagged returns from the current fetch are written into the assembly buffer; byte i goes to bits [8i+7:8i].
- Completion: at the edge where byte 3 returns, register `if_inst`=buffer and pulse `if_done`=1; next state is IDLE.
  - `if_inst` holds its value until the next completion.
- Preemption: if `mem_req`=1 at any FETCH edge, MEM takes that edge. The fetch is aborted, its in-flight tags are invalidated and the collected bytes are discarded; next state is HOLD.
- HOLD → FETCH: at the first edge with `mem_req`=0 and `if_req`=1, restart from byte 0 using the latched base.
- `if_flush`=1 at any edge: go to IDLE, invalidate IF tags, no `if_done`.
  - This takes priority over completion at the same edge.
- `if_busy`=1 in FETCH and HOLD, 0 in IDLE.

## Timing
- Reset (asynchronous assert): all outputs and state are 0 and the state is IDLE.
  - Cleared: `ram_a`, `ram_wr`, `ram_dout`, `if_inst`, `if_done`, `if_busy`, tags and buffer.
  - Reset mid-fetch discards everything; the first fetch after release restarts from scratch.
- MEM read latency: request edge t, data sampled by MEM at t+2. Throughput is one byte per cycle, back-to-back.
- IF latency when uncontended: start edge t0, issues at t0..t0+3, returns t0+2..t0+5, `if_done` high in the cycle after edge t0+5.
- An `if_req` and `mem_req` at the same IDLE edge: MEM wins and the fetch starts at the first free edge.
- Back-to-back fetch: at the same edge `if_done` is registered, a new `if_req` cannot start; the earliest next start is the following edge.

## Test plan
- Uncontended fetch: RAM[0x100..0x103]=13,05,10,00 (hex); `if_req` with `if_addr`=0x100 at edge 0 → `ram_a`=0x100..0x103 at edges 0..3; `if_done` after edge 5 with `if_inst`=0x00100513.
- MEM byte read and write: write 0xAB to 0x2000 at edge 0, read 0x2000 at edge 1 → `ram_wr`=1 at edge 0, 0 at edge 1; `mem_rdata`=0xAB sampled at edge 3.
- Preemption: start a fetch at 0x100 and pulse `mem_req` (read 0x2000) at edge 2 → byte 2 is not issued, state goes to HOLD; restart at edge 3 at 0x100; `if_done` after edge 8 with the correct word, and no MEM byte is merged into it.
- Flush racing completion: `if_flush`=1 at edge 5 of an uncontended fetch → no `if_done`, `if_busy`=0 after edge 5, `if_inst` unchanged.
- Wrap-around: `if_addr`=0x1FFFE, `ADDR_W`=17 → `ram_a`=0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Async reset mid-fetch: drop `rst` between edges 2 and 3 → outputs 0 immediately and no `if_done`; after release, an `if_req` at 0x100 completes in 6 edges.
